// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM state encoding and word width shared by the SPI flash responder
package spi_flash_pkg;
   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;
   localparam int         WORD_W        = 16;
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, FETCH, DATA, IGNORE} state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-flop synchronizers for cs/sclk/mosi plus sclk rise/fall pulses in the clk domain
module spi_pin_sync (
   input  logic clk,
   input  logic rst,
   input  logic cs,
   input  logic sclk,
   input  logic mosi,
   output logic cs_s,
   output logic mosi_s,
   output logic rise,
   output logic fall
);
   logic [1:0] cs_q, mosi_q;
   logic [2:0] sclk_q;
   // cs resets deasserted so the FSM stays idle while the pins settle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cs_q   <= 2'b11;
         mosi_q <= 2'b00;
         sclk_q <= 3'b000;
      end else begin
         cs_q   <= {cs_q[0], cs};
         mosi_q <= {mosi_q[0], mosi};
         sclk_q <= {sclk_q[1:0], sclk};
      end
   assign cs_s   = cs_q[1];
   assign mosi_s = mosi_q[1];
   assign rise   = sclk_q[1] & ~sclk_q[2];
   assign fall   = ~sclk_q[1] & sclk_q[2];
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: mode-0 single-SPI flash target streaming 16-bit words from a word-addressed memory.
// SPI_FAST_READ_EN enables opcode 0x0B with DUMMY_BITS dummy clocks.
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int MEM_AW     = 16,
   parameter int ADDR_BITS  = 24,
   parameter int DUMMY_BITS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   output logic              spi_miso_o,
   output logic              spi_miso_oe,
   output logic              mem_rd,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              active
);
   localparam int CW = $clog2(ADDR_BITS + DUMMY_BITS + 1);
   logic              cs_s, mosi_s, rise, fall, rd_q;
   state_t            state;
   logic [CW-1:0]     cnt;
   logic [4:0]        bit_cnt;
   logic [MEM_AW-1:0] a_sh, a_next, waddr;
   logic [WORD_W-1:0] shreg, next_word;
`ifdef SPI_FAST_READ_EN
   logic              fast;
`endif
   spi_pin_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .cs     (spi_cs),
      .sclk   (spi_sclk),
      .mosi   (spi_mosi),
      .cs_s   (cs_s),
      .mosi_s (mosi_s),
      .rise   (rise),
      .fall   (fall)
   );
   // only the low MEM_AW address bits are kept; the opcode lands in the low byte
   assign a_next     = {a_sh[MEM_AW-2:0], mosi_s};
   assign spi_miso_o = shreg[WORD_W-1];
   assign active     = state != IDLE;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         a_sh        <= '0;
         waddr       <= '0;
         shreg       <= '0;
         next_word   <= '0;
         rd_q        <= 1'b0;
         mem_rd      <= 1'b0;
         mem_addr    <= '0;
         spi_miso_oe <= 1'b0;
`ifdef SPI_FAST_READ_EN
         fast        <= 1'b0;
`endif
      end else begin
         mem_rd <= 1'b0;
         rd_q   <= mem_rd;
         if (cs_s) begin
            state       <= IDLE;
            spi_miso_oe <= 1'b0;
            shreg       <= '0;
            cnt         <= '0;
            bit_cnt     <= '0;
         end else
            case (state)
               IDLE: begin
                  state <= CMD;
                  cnt   <= '0;
               end
               CMD:
                  if (rise) begin
                     a_sh <= a_next;
                     cnt  <= cnt + CW'(1);
                     if (cnt == CW'(7)) begin
                        cnt   <= '0;
`ifdef SPI_FAST_READ_EN
                        fast  <= a_next[7:0] == CMD_FAST_READ;
                        state <= (a_next[7:0] == CMD_READ || a_next[7:0] == CMD_FAST_READ) ? ADDR : IGNORE;
`else
                        state <= a_next[7:0] == CMD_READ ? ADDR : IGNORE;
`endif
                     end
                  end
               ADDR:
                  if (rise) begin
                     a_sh <= a_next;
                     cnt  <= cnt + CW'(1);
                     if (cnt == CW'(ADDR_BITS - 1)) begin
                        cnt   <= '0;
`ifdef SPI_FAST_READ_EN
                        state <= fast ? DUMMY : FETCH;
`else
                        state <= FETCH;
`endif
                     end
                  end
`ifdef SPI_FAST_READ_EN
               DUMMY:
                  if (rise) begin
                     cnt <= cnt + CW'(1);
                     if (cnt == CW'(DUMMY_BITS - 1)) begin
                        cnt   <= '0;
                        state <= FETCH;
                     end
                  end
`endif
               // issue the read, then load the word the clk after the strobe
               FETCH:
                  if (rd_q) begin
                     shreg       <= mem_rdata;
                     spi_miso_oe <= 1'b1;
                     bit_cnt     <= '0;
                     state       <= DATA;
                  end else if (!mem_rd) begin
                     mem_rd   <= 1'b1;
                     mem_addr <= a_sh;
                     waddr    <= a_sh;
                  end
               DATA: begin
                  if (rd_q)
                     next_word <= mem_rdata;
                  if (rise) begin
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= waddr + MEM_AW'(1);
                     end
                  end else if (fall && bit_cnt != 5'd0) begin
                     if (bit_cnt == 5'd16) begin
                        shreg   <= next_word;
                        bit_cnt <= '0;
                        waddr   <= waddr + MEM_AW'(1);
                     end else
                        shreg <= {shreg[WORD_W-2:0], 1'b0};
                  end
               end
               IGNORE: ;
               default: state <= IDLE;
            endcase
      end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: SPI initiator model with a word scoreboard checked against a flat memory model
module tb_spi_flash_responder;
   localparam int H = 6;
   logic        clk = 1'b0, rst = 1'b1;
   logic        spi_cs = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
   logic        spi_miso_o, spi_miso_oe, mem_rd, active;
   logic [15:0] mem_addr, mem_rdata;
   logic [15:0] mem [0:65535];
   logic [15:0] exp_q [$];
   logic [15:0] rx, rx_word;
   int          bitn, rd_cnt = 0, tests = 0, fails = 0;
   event        word_ev;

   spi_flash_responder dut (
      .clk         (clk),
      .rst         (rst),
      .spi_cs      (spi_cs),
      .spi_sclk    (spi_sclk),
      .spi_mosi    (spi_mosi),
      .spi_miso_o  (spi_miso_o),
      .spi_miso_oe (spi_miso_oe),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .active      (active)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
   always @(posedge clk) if (mem_rd) rd_cnt <= rd_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // data=1: bits are read words (oe must be on); otherwise MISO must be hi-Z
   task automatic bits(input logic [31:0] d, input int n, input bit data);
      for (int i = n - 1; i >= 0; i--) begin
         spi_mosi = d[i];
         clks(H);
         spi_sclk = 1'b1;
         if (data) begin
            chk("oe_data", spi_miso_oe, 1);
            rx = {rx[14:0], spi_miso_o};
            bitn++;
            if (bitn == 16) begin
               bitn    = 0;
               rx_word = rx;
               ->word_ev;
            end
         end else
            chk("oe_hiz", spi_miso_oe, 0);
         clks(H);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic txn(input logic [7:0] op, input logic [15:0] a, input int nw, input bit ok, input bit fast);
      int r0;
      r0   = rd_cnt;
      bitn = 0;
      if (ok)
         for (int i = 0; i < nw; i++) exp_q.push_back(mem[a + 16'(i)]);
      spi_cs = 1'b0;
      clks(4);
      bits({24'h0, op}, 8, 0);
      bits({8'h0, 8'($urandom), a}, 24, 0);
      if (fast) bits(32'h0, 8, 0);
      repeat (nw) bits(32'h0, 16, ok);
      spi_mosi = 1'b0;
      clks(H);
      spi_cs = 1'b1;
      clks(6);
      chk("oe_after_cs", spi_miso_oe, 0);
      chk("active_idle", active, 0);
      chk("rd_pulses", rd_cnt - r0, ok ? nw + 1 : 0);
   endtask

   initial forever begin
      @(word_ev);
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL sb_underflow: got %h expected no word", rx_word);
      end else
         chk("miso_word", rx_word, exp_q.pop_front());
   end

   initial begin
      logic [7:0]  op;
      logic [15:0] a;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[16'h1234] = 16'hABCD;
      mem[16'h1235] = 16'h5566;
      mem[16'hFFFF] = 16'hDEAD;
      mem[16'h0000] = 16'h1111;
      mem[16'h9000] = 16'hDEAD;
      clks(3);
      chk("rst_active", active, 0);
      chk("rst_oe", spi_miso_oe, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_miso", spi_miso_o, 0);
      rst = 1'b0;
      clks(4);
      txn(8'h03, 16'h1234, 1, 1, 0);
      txn(8'h03, 16'h1234, 2, 1, 0);
      txn(8'h03, 16'hFFFF, 2, 1, 0);
      txn(8'h9F, 16'h1234, 1, 0, 0);
      txn(8'h03, 16'h1234, 1, 1, 0);
      spi_cs = 1'b0;
      clks(4);
      bits(32'h03, 8, 0);
      bits(32'h009000 >> 14, 10, 0);
      spi_cs = 1'b1;
      clks(6);
      chk("abort_active", active, 0);
      txn(8'h03, 16'h9000, 1, 1, 0);
      bitn   = 0;
      spi_cs = 1'b0;
      clks(4);
      bits(32'h03, 8, 0);
      bits(32'h001234, 24, 0);
      bits(32'h0, 5, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_oe", spi_miso_oe, 0);
      chk("rst_mid_active", active, 0);
      spi_cs = 1'b1;
      clks(2);
      rst = 1'b0;
      clks(4);
      txn(8'h03, 16'h1235, 1, 1, 0);
`ifdef SPI_FAST_READ_EN
      txn(8'h0B, 16'h1234, 1, 1, 1);
`else
      txn(8'h0B, 16'h1234, 1, 0, 1);
`endif
      repeat (10) begin
         op = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'h03;
         a  = ($urandom_range(0, 2) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
         txn(op, a, $urandom_range(1, 3), op == 8'h03, 0);
      end
      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
